l1_mem_responder: RTL and testbench
===================================

# l1_mem_responder

Memory-side responder for the L1 data cache's line-refill/writeback port. It accepts one line request at a time from the L1D miss path, models main-memory access latency with a counter, and then either streams the line back as word beats with backpressure, or absorbs a writeback line beat by beat and acknowledges it. It sits below `l1d` and is the synthesizable backing-memory model used by cache benches.

## Interface
Parameters:
- `MEM_WORDS`, 4096: backing store depth in 32-bit words; power of two.
- `LATENCY`, 4: cycles between request acceptance and the first read beat, or between the last write beat and the ack; 0..255.
- `DATA_WIDTH`, 32: beat width in bits.

Ports (one clock; reset is synchronous and active-low, clock `clk`, reset `rst_n`):
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `l1_mem_req_valid` in 1: line request present.
- `l1_mem_req_ready` out 1: responder can accept a request.
- `l1_mem_req_write` in 1: 0 = refill (read line), 1 = writeback.
- `l1_mem_req_addr` in ADDR_WIDTH: byte address of the line.
- `l1_mem_wvalid` in 1: writeback beat valid.
- `l1_mem_wdata` in DATA_WIDTH: writeback beat.
- `mem_l1_wready` out 1: writeback beat accepted.
- `mem_l1_wack` out 1: one-cycle pulse when the writeback is complete.
- `mem_l1_rvalid` out 1: refill beat valid.
- `mem_l1_rdata` out DATA_WIDTH: refill beat.
- `mem_l1_rlast` out 1: marks the final refill beat.
- `l1_mem_rready` in 1: L1D accepts the refill beat.

## Operation
- BEATS = L1_LINE_SIZE*8/DATA_WIDTH. Beat counter width is clog2(BEATS).
- Line base: the request address has its low L1_OFFSET bits forced to zero. The word index is (base>>2 + beat) mod MEM_WORDS, so out-of-range addresses wrap silently.
- The FSM has five states:
  - IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch the base, latch `write`, load the latency counter with LATENCY, and clear the beat counter. A read goes to R_WAIT, or to R_DATA if LATENCY=0. A write goes to W_DATA.
  - R_WAIT: decrement the counter. At counter==1, go to R_DATA.
  - R_DATA: `rvalid`=1, `rdata`=mem[word index], `rlast`=(beat==BEATS-1). Advance only on `rvalid`&&`rready`. On the last-beat handshake, go to IDLE. `rdata` and `rlast` hold stable while stalled.
  - W_DATA: `wready`=1. Each `wvalid`&&`wready` writes mem[word index] and increments the beat. After the last beat, load LATENCY and go to W_WAIT, or to W_ACK if LATENCY=0.
  - W_WAIT: decrement the counter. At counter==1, go to W_ACK.
  - W_ACK: `wack`=1 for exactly one cycle, then go to IDLE.
- Only one transaction is outstanding. `req_ready` is 0 in every state except IDLE.
- `wvalid` outside W_DATA is ignored and `wready` stays 0. `rready` outside R_DATA is ignored.
- Memory contents are not reset and power up as X. A bench preloads them via hierarchical access or by issuing writebacks.

## Timing
- Reset values: `req_ready`=0 during reset and 1 in the first cycle after `rst_n` rises. `wready`, `wack`, `rvalid`, `rlast` are 0. `rdata` is 0. The FSM is in IDLE and the counters are 0.
- Read latency: request accepted at edge N, first `rvalid` high after edge N+1+LATENCY. With `rready` held high, a full line takes BEATS consecutive cycles.
- Write: `wready` is high from edge N+1. The ack pulse follows LATENCY+1 edges after the last beat handshake.
- A new request can be accepted in the cycle after the last read beat handshake or after the `wack` cycle. There is no back-to-back overlap.
- `rst_n` low mid-transaction: at the next edge, go to IDLE, clear all outputs, and abandon any partial line. Memory words already written in W_DATA stay written.
- The write enable and data for mem are registered on the same edge as the handshake. A read of the same word issued later sees the new value.

## Structure
- `cache_pkg` already holds ADDR_WIDTH, L1_LINE_SIZE and L1_OFFSET. Add to it a `mem_state_t` enum (IDLE, R_WAIT, R_DATA, W_DATA, W_WAIT, W_ACK) and L1_BEATS = L1_LINE_SIZE*8/32.
- One sub-module is natural: `mem_word_ram`, a single-port synchronous-write, asynchronous-read array of MEM_WORDS×DATA_WIDTH. The FSM, counters and handshake logic stay in `l1_mem_responder`.

## Test plan
- Read, LATENCY=4, `rready`=1: preload words 0x40..0x4F = 0xA000_0000+i, request addr 0x0000_0104 → first `rvalid` 5 cycles after acceptance, beats 0xA0000000..0xA000000F on consecutive cycles, `rlast` only on the 16th beat (L1_LINE_SIZE=64).
- Read backpressure: same request, `rready` toggled 1,0,0,1,… → `rdata` held stable while `rready`=0, no beat skipped or repeated, still 16 handshakes.
- Writeback, then readback: write 16 beats 0x5555_0000+i to addr 0x200 with `wvalid` gaps → `wack` pulses exactly once, LATENCY+1 cycles after the last beat. A read of 0x200 returns the same 16 words.
- LATENCY=0 plus wrap: with MEM_WORDS=4096, read addr 0x0000_4000 → the first beat comes the cycle after acceptance and returns word 0 content.
- `req_ready` gating: `req_valid` held high through a read → exactly one acceptance per transaction, `req_ready`=0 from acceptance until after the last beat.
- Reset mid-read at beat 7 → the next edge gives `rvalid`=0, `req_ready`=1 one cycle after `rst_n` rises. A new request completes normally with the correct data.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry, responder state encoding and line address helper
package cache_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int L1_LINE_SIZE = 64;
    localparam int L1_OFFSET    = 6;
    localparam int L1_BEATS     = L1_LINE_SIZE * 8 / 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R_WAIT = 3'd1,
        R_DATA = 3'd2,
        W_DATA = 3'd3,
        W_WAIT = 3'd4,
        W_ACK  = 3'd5
    } mem_state_t;

    // Word address of the first word of the line that contains a byte address
    function automatic logic [ADDR_WIDTH-1:0] line_word(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] base;
        base = {addr[ADDR_WIDTH-1:L1_OFFSET], {L1_OFFSET{1'b0}}};
        return base >> 2;
    endfunction

endpackage

// File: rtl/mem_word_ram.sv
// rtl/mem_word_ram.sv - single-port word array, synchronous write, asynchronous read
module mem_word_ram #(
    parameter int WORDS = 4096,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; they behave like real backing memory
    logic [WIDTH-1:0] mem [WORDS];

    // Write commits on the same edge as the beat handshake
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/l1_mem_responder.sv
// rtl/l1_mem_responder.sv - latency-modelling line refill/writeback responder below the L1D
module l1_mem_responder
    import cache_pkg::*;
#(
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  l1_mem_req_valid,
    output logic                  l1_mem_req_ready,
    input  logic                  l1_mem_req_write,
    input  logic [ADDR_WIDTH-1:0] l1_mem_req_addr,
    input  logic                  l1_mem_wvalid,
    input  logic [DATA_WIDTH-1:0] l1_mem_wdata,
    output logic                  mem_l1_wready,
    output logic                  mem_l1_wack,
    output logic                  mem_l1_rvalid,
    output logic [DATA_WIDTH-1:0] mem_l1_rdata,
    output logic                  mem_l1_rlast,
    input  logic                  l1_mem_rready
);

    localparam int BEATS  = L1_LINE_SIZE * 8 / DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = $clog2(MEM_WORDS);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [7:0]        LAT_LOAD  = 8'(LATENCY);

    mem_state_t            state;
    logic [7:0]            lat_cnt;
    logic [BEAT_W-1:0]     beat;
    logic [IDX_W-1:0]      base_word;
    logic [IDX_W-1:0]      word_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ram_we;
    logic                  at_last_beat;

    // Index wraps modulo the array depth, so out-of-range lines alias silently
    assign word_idx     = base_word + IDX_W'(beat);
    assign at_last_beat = (beat == LAST_BEAT);

    // Handshake outputs decode straight from the state; ready is held low while reset is asserted
    assign l1_mem_req_ready = (state == IDLE) && rst_n;
    assign mem_l1_rvalid    = (state == R_DATA);
    assign mem_l1_rdata     = mem_l1_rvalid ? ram_rdata : '0;
    assign mem_l1_rlast     = mem_l1_rvalid && at_last_beat;
    assign mem_l1_wready    = (state == W_DATA);
    assign mem_l1_wack      = (state == W_ACK);
    assign ram_we           = mem_l1_wready && l1_mem_wvalid;

    mem_word_ram #(
        .WORDS (MEM_WORDS),
        .WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (word_idx),
        .wdata (l1_mem_wdata),
        .rdata (ram_rdata)
    );

    // Transaction FSM with latency countdown and beat counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            beat      <= '0;
            base_word <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (l1_mem_req_valid) begin
                        base_word <= IDX_W'(line_word(l1_mem_req_addr));
                        lat_cnt   <= LAT_LOAD;
                        beat      <= '0;
                        if (l1_mem_req_write) begin
                            state <= W_DATA;
                        end else if (LATENCY == 0) begin
                            state <= R_DATA;
                        end else begin
                            state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    lat_cnt <= lat_cnt - 8'd1;
                    if (lat_cnt == 8'd1) begin
                        state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (l1_mem_rready) begin
                        if (at_last_beat) begin
                            beat  <= '0;
                            state <= IDLE;
                        end else begin
                            beat <= beat + BEAT_ONE;
                        end
                    end
                end
                W_DATA: begin
                    if (l1_mem_wvalid) begin
                        if (at_last_beat) begin
                            beat    <= '0;
                            lat_cnt <= LAT_LOAD;
                            state   <= (LATENCY == 0) ? W_ACK : W_WAIT;
                        end else begin
                            beat <= beat + BEAT_ONE;
                        end
                    end
                end
                W_WAIT: begin
                    lat_cnt <= lat_cnt - 8'd1;
                    if (lat_cnt == 8'd1) begin
                        state <= W_ACK;
                    end
                end
                W_ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mem_responder.sv
// tb/tb_l1_mem_responder.sv - scoreboard bench for l1_mem_responder at LATENCY 4 and 0
module tb_l1_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic        wvalid;
    logic [31:0] wdata;
    logic        rready;

    logic        req_ready_a, wready_a, wack_a, rvalid_a, rlast_a;
    logic [31:0] rdata_a;
    logic        req_ready_b, wready_b, wack_b, rvalid_b, rlast_b;
    logic [31:0] rdata_b;

    logic        req_ready, wready, wack, rvalid, rlast;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;
    int lat;

    logic [31:0] model_a [4096];
    logic [31:0] model_b [4096];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    l1_mem_responder #(.MEM_WORDS(4096), .LATENCY(4), .DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .l1_mem_req_valid (req_valid && !sel),
        .l1_mem_req_ready (req_ready_a),
        .l1_mem_req_write (req_write),
        .l1_mem_req_addr  (req_addr),
        .l1_mem_wvalid    (wvalid && !sel),
        .l1_mem_wdata     (wdata),
        .mem_l1_wready    (wready_a),
        .mem_l1_wack      (wack_a),
        .mem_l1_rvalid    (rvalid_a),
        .mem_l1_rdata     (rdata_a),
        .mem_l1_rlast     (rlast_a),
        .l1_mem_rready    (rready && !sel)
    );

    l1_mem_responder #(.MEM_WORDS(4096), .LATENCY(0), .DATA_WIDTH(32)) dut0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .l1_mem_req_valid (req_valid && sel),
        .l1_mem_req_ready (req_ready_b),
        .l1_mem_req_write (req_write),
        .l1_mem_req_addr  (req_addr),
        .l1_mem_wvalid    (wvalid && sel),
        .l1_mem_wdata     (wdata),
        .mem_l1_wready    (wready_b),
        .mem_l1_wack      (wack_b),
        .mem_l1_rvalid    (rvalid_b),
        .mem_l1_rdata     (rdata_b),
        .mem_l1_rlast     (rlast_b),
        .l1_mem_rready    (rready && sel)
    );

    assign req_ready = sel ? req_ready_b : req_ready_a;
    assign wready    = sel ? wready_b    : wready_a;
    assign wack      = sel ? wack_b      : wack_a;
    assign rvalid    = sel ? rvalid_b    : rvalid_a;
    assign rdata     = sel ? rdata_b     : rdata_a;
    assign rlast     = sel ? rlast_b     : rlast_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int line_base(input logic [31:0] addr);
        return int'((addr >> 2) & 32'h0000_0FF0);
    endfunction

    task automatic write_line(input logic [31:0] addr, input logic [31:0] dbase, input bit gaps);
        int cyc, beats, base, acks, ack_at;
        base  = line_base(addr);
        beats = 0;
        cyc   = 0;
        acks  = 0;
        ack_at = -1;
        @(negedge clk);
        check("req_ready_before_write", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        wvalid    = 1'b0;
        while (beats < 16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            req_write = 1'b0;
            if (cyc == 1) check("wready_after_accept", 32'(wready), 32'd1);
            wvalid = !(gaps && (cyc % 3 == 2));
            wdata  = dbase + 32'(beats);
            if (wack) acks++;
            if (wvalid && wready) begin
                if (sel) model_b[(base + beats) % 4096] = wdata;
                else     model_a[(base + beats) % 4096] = wdata;
                beats++;
            end
        end
        check("write_beats", 32'(beats), 32'd16);
        for (int i = 1; i <= lat + 3; i++) begin
            @(negedge clk);
            wvalid = 1'b0;
            if (wack) begin
                acks++;
                if (ack_at < 0) ack_at = i;
            end
        end
        check("wack_delay", 32'(ack_at), 32'(lat + 1));
        check("wack_count", 32'(acks), 32'd1);
    endtask

    task automatic read_line(input logic [31:0] addr, input int mode, input bit hold);
        int cyc, beats, first, rv_idx, base;
        bit ready_leak;
        base = line_base(addr);
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(sel ? model_b[(base + i) % 4096] : model_a[(base + i) % 4096]);
        end
        @(negedge clk);
        check("req_ready_before_read", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = addr;
        cyc        = 0;
        beats      = 0;
        first      = -1;
        rv_idx     = 0;
        ready_leak = 1'b0;
        while (beats < 16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold) req_valid = 1'b0;
            if (req_ready) ready_leak = 1'b1;
            if (mode == 0) rready = 1'b1;
            else           rready = rvalid && (rv_idx % 3 == 0);
            if (rvalid) begin
                if (first < 0) begin
                    first = cyc;
                    check("first_beat_latency", 32'(first), 32'(lat + 1));
                end
                check("rdata", rdata, exp_q[0]);
                check("rlast", 32'(rlast), 32'(exp_q.size() == 1));
                if (rready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
                rv_idx++;
            end
        end
        req_valid = 1'b0;
        check("read_beats", 32'(beats), 32'd16);
        check("req_ready_low_during_read", 32'(ready_leak), 32'd0);
        @(negedge clk);
        rready = 1'b0;
        check("req_ready_after_read", 32'(req_ready), 32'd1);
        check("rvalid_after_read", 32'(rvalid), 32'd0);
    endtask

    initial begin
        int cyc, beats;
        sel       = 1'b0;
        lat       = 4;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        wvalid    = 1'b0;
        wdata     = '0;
        rready    = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_wready", 32'(wready), 32'd0);
        check("reset_wack", 32'(wack), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rlast", 32'(rlast), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", 32'(req_ready), 32'd1);

        // Preload 0x40..0x4F by writeback, then streaming and stalled refills
        write_line(32'h0000_0100, 32'hA000_0000, 1'b0);
        read_line(32'h0000_0104, 0, 1'b0);
        read_line(32'h0000_0104, 1, 1'b0);

        // Writeback with gaps, then readback
        write_line(32'h0000_0200, 32'h5555_0000, 1'b1);
        read_line(32'h0000_0200, 0, 1'b0);

        // Request valid held high through the whole refill
        read_line(32'h0000_013C, 0, 1'b1);

        // Reset while beat 7 is being presented
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0104;
        rready    = 1'b1;
        cyc       = 0;
        beats     = 0;
        while (beats < 7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            if (rvalid) beats++;
        end
        @(negedge clk);
        check("beat7_data", rdata, 32'hA000_0007);
        rst_n  = 1'b0;
        rready = 1'b0;
        @(negedge clk);
        check("mid_reset_rvalid", 32'(rvalid), 32'd0);
        check("mid_reset_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_mid_reset", 32'(req_ready), 32'd1);
        read_line(32'h0000_0104, 0, 1'b0);

        // Zero-latency instance: writeback to word 0, refill through a wrapping address
        sel = 1'b1;
        lat = 0;
        write_line(32'h0000_0000, 32'hC0DE_0000, 1'b1);
        read_line(32'h0000_4000, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
